// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding and
// access-latency counter width.
package dmem_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      PIPE   = 1'b0,
      LOADER = 1'b1
   } owner_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant decision between the MEM stage and the loader port. Fixed pipeline
// priority by default; round-robin on ties when DMEM_ARB_RR_EN is defined.
module dmem_arb_grant
   import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
   input  logic   clk,
   input  logic   rst,
   input  logic   take,
`endif
   input  logic   p_req,
   input  logic   l_req,
   output logic   gnt_any,
   output owner_t gnt_owner
);

`ifdef DMEM_ARB_RR_EN
   owner_t last_owner;

   // Reset to LOADER so the pipeline wins the very first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_owner <= LOADER;
      end else if (take) begin
         last_owner <= gnt_owner;
      end
   end
`endif

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt_any   = p_req | l_req;
      gnt_owner = PIPE;
      if (l_req && !p_req) begin
         gnt_owner = LOADER;
      end
`ifdef DMEM_ARB_RR_EN
      else if (l_req && p_req && (last_owner == PIPE)) begin
         gnt_owner = LOADER;
      end
`endif
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequences a fixed-latency single-port data memory between the MEM stage and
// a loader/debug port. Optional round-robin arbitration via DMEM_ARB_RR_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_rd_en,
   input  logic              p_wr_en,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_freeze,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_done,
   output logic [DATA_W-1:0] l_rdata,
   output logic              m_rd_en,
   output logic              m_wr_en,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata
);

   state_t           state, state_nxt;
   owner_t           owner;
   owner_t           gnt_owner;
   logic [CNT_W-1:0] cnt;
   logic             p_req;
   logic             gnt_any;

   assign p_req = p_rd_en | p_wr_en;

   dmem_arb_grant u_grant (
`ifdef DMEM_ARB_RR_EN
      .clk       (clk),
      .rst       (rst),
      .take      (state == IDLE && gnt_any),
`endif
      .p_req     (p_req),
      .l_req     (l_req),
      .gnt_any   (gnt_any),
      .gnt_owner (gnt_owner)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (gnt_any) state_nxt = BUSY;
         BUSY:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command is registered at grant, so requester inputs may change while BUSY.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner   <= PIPE;
         cnt     <= '0;
         m_rd_en <= 1'b0;
         m_wr_en <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         p_rdata <= '0;
         l_rdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (gnt_any) begin
                  owner <= gnt_owner;
                  cnt   <= CNT_W'(MEM_LAT - 1);
                  if (gnt_owner == PIPE) begin
                     m_addr  <= p_addr;
                     m_wdata <= p_wdata;
                     m_wr_en <= p_wr_en;
                     m_rd_en <= p_rd_en & ~p_wr_en;
                  end else begin
                     m_addr  <= l_addr;
                     m_wdata <= l_wdata;
                     m_wr_en <= l_we;
                     m_rd_en <= ~l_we;
                  end
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  m_rd_en <= 1'b0;
                  m_wr_en <= 1'b0;
                  if (m_rd_en) begin
                     if (owner == PIPE) p_rdata <= m_rdata;
                     else               l_rdata <= m_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign p_freeze = p_req & ~(state == DONE && owner == PIPE);
   assign l_gnt    = (owner == LOADER) && (state == BUSY || state == DONE);
   assign l_done   = (owner == LOADER) && (state == DONE);

endmodule
